// File: rtl/mdu.sv
// mdu: multiply/divide unit beside the ALU; owns the HI/LO result registers.
//   Latency: MULT/MULTU write {hi,lo} MUL_LAT edges after the start edge; DIV/DIVU
//   write WIDTH+1 edges after it; MTHI/MTLO write at the start edge. While busy,
//   new starts are ignored (no queuing); cancel aborts the op with no write.
// Ports:
//   i_clk, i_rst           clock and synchronous active-high reset
//   i_start, i_op          launch request and operation code (sampled only when idle)
//   i_a, i_b               rs/rt operands, latched at the start edge
//   i_cancel               pipeline flush: abort in-flight op, blocks a same-cycle start
//   o_busy                 multi-cycle op in progress
//   o_done                 one-cycle pulse when hi/lo were just written by MULT*/DIV*
//   o_hi, o_lo             committed HI/LO registers
module mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand registers. For multiply r_opa/r_opb hold the raw operands; for divide
  // r_opa holds the dividend magnitude and shifts left into the quotient while
  // r_rem accumulates the partial remainder.
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_a_raw;   // original dividend, returned in hi on divide-by-zero
  logic             r_signed;  // multiply: sign-extend operands
  logic             r_neg_q;   // divide: negate quotient at fix-up
  logic             r_neg_r;   // divide: negate remainder at fix-up

  logic w_launch, w_launch_div, w_mthi, w_mtlo, w_iter, w_mul_wr, w_div_wr;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_launch_div = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    w_iter       = 1'b0;
    w_mul_wr     = 1'b0;
    w_div_wr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // cancel in the same cycle as start suppresses the launch entirely
        if (i_start && !i_cancel) begin
          case (i_op)
            OP_MULT, OP_MULTU: begin
              w_state_nxt = S_MUL;
              w_launch    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              w_state_nxt  = S_DIV;
              w_launch     = 1'b1;
              w_launch_div = 1'b1;
            end
            OP_MTHI: w_mthi = 1'b1;
            OP_MTLO: w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (i_cancel) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(MUL_LAT)) begin
          w_state_nxt = S_IDLE;
          w_mul_wr    = 1'b1;
        end
      end
      S_DIV: begin
        if (i_cancel) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_iter = 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_div_wr    = !i_cancel;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  logic             w_op_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [2*WIDTH-1:0] w_ax, w_bx, w_prod;
  logic [WIDTH:0]   w_shift, w_diff;

  assign w_op_signed = ~i_op[0];
  assign w_a_mag     = (w_op_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag     = (w_op_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

  // Sign-extending to 2*WIDTH and keeping the low 2*WIDTH product bits gives the
  // correct signed or unsigned full-width product from a single multiplier.
  assign w_ax   = {{WIDTH{r_signed & r_opa[WIDTH-1]}}, r_opa};
  assign w_bx   = {{WIDTH{r_signed & r_opb[WIDTH-1]}}, r_opb};
  assign w_prod = w_ax * w_bx;

  // Restoring step: shift next dividend bit into the remainder, try subtracting.
  assign w_shift = {r_rem, r_opa[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_rem    <= '0;
      r_a_raw  <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= w_mul_wr | w_div_wr;

      if (w_launch) begin
        r_signed <= w_op_signed;
        r_a_raw  <= i_a;
        r_rem    <= '0;
        r_neg_q  <= w_op_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_neg_r  <= w_op_signed & i_a[WIDTH-1];
        if (w_launch_div) begin
          r_opa <= w_a_mag;
          r_opb <= w_b_mag;
          r_cnt <= '0;
        end else begin
          r_opa <= i_a;
          r_opb <= i_b;
          r_cnt <= CW'(1);
        end
      end else if (r_state == S_MUL) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_iter) begin
        r_cnt <= r_cnt + CW'(1);
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_opa <= {r_opa[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_opa <= {r_opa[WIDTH-2:0], 1'b0};
        end
      end

      if (w_mul_wr) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end

      if (w_div_wr) begin
        if (r_opb == '0) begin
          r_lo <= {WIDTH{1'b1}};
          r_hi <= r_a_raw;
        end else begin
          // MIN/-1 falls out naturally: magnitude 2^(W-1) negated wraps to itself
          r_lo <= r_neg_q ? -r_opa : r_opa;
          r_hi <= r_neg_r ? -r_rem : r_rem;
        end
      end

      if (w_mthi) r_hi <= i_a;
      if (w_mtlo) r_lo <= i_a;
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu against an arithmetic reference model.
//   Directed cases (signs, divide-by-zero, overflow, ignored start, cancel, reset)
//   followed by randomized MULT/MULTU/DIV/DIVU operations.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu #(.WIDTH(32), .MUL_LAT(3)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_cancel(cancel),
    .o_busy  (busy),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference result {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = '0;
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;   // 64-bit division truncates toward zero and avoids overflow
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
      default: res = {exp_hi, exp_lo};
    endcase
    return res;
  endfunction

  // Launch one multi-cycle op and follow it to its result (or cancel) edge.
  // cancel_after / start_after: raise cancel / a stray MULT start right after that edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int cancel_after, input int start_after);
    int lat;
    logic [63:0] old_v;
    logic [63:0] res;
    logic ok;
    lat   = o[1] ? 33 : 3;
    old_v = {exp_hi, exp_lo};
    res   = ref_result(o, x, y);
    ok    = 1'b1;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom; b = $urandom;
    chk({tag, "_e0_busy"}, 64'(busy), 64'd1);
    chk({tag, "_e0_done"}, 64'(done), 64'd0);
    for (int e = 1; e <= lat; e++) begin
      if (e - 1 == start_after) begin start = 1'b1; op = 3'd0; end
      if (e - 1 == cancel_after) cancel = 1'b1;
      step();
      start  = 1'b0;
      cancel = 1'b0;
      if (e - 1 == cancel_after) begin
        chk({tag, "_cancel_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cancel_done"}, 64'(done), 64'd0);
        chk({tag, "_cancel_hilo"}, {hi, lo}, old_v);
        step();
        chk({tag, "_cancel_nodone"}, 64'(done), 64'd0);
        return;
      end
      if (e < lat) begin
        if (busy !== 1'b1 || done !== 1'b0 || {hi, lo} !== old_v) ok = 1'b0;
      end else begin
        chk({tag, "_wait"}, 64'(ok), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, res);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
      end
    end
  endtask

  initial begin
    logic seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    step();

    run_op("mult",  3'd0, 32'hFFFFFFFF, 32'd2, -1, -1);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, -1, -1);
    run_op("div",   3'd2, 32'hFFFFFFF9, 32'd2, -1, -1);
    run_op("divu",  3'd3, 32'd100, 32'd7, -1, -1);
    run_op("div0",  3'd2, 32'd5, 32'd0, -1, -1);
    run_op("divu0", 3'd3, 32'h87654321, 32'd0, -1, -1);
    run_op("divov", 3'd2, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    run_op("divneg", 3'd2, 32'd7, 32'hFFFFFFFE, -1, -1);
    run_op("ignstart", 3'd2, 32'd1000, 32'd3, -1, 5);
    run_op("cancel", 3'd2, 32'd1000, 32'd3, 10, -1);
    run_op("cancelres", 3'd0, 32'd1234, 32'd5678, 2, -1);

    // MTHI / MTLO: single-edge writes, never busy
    op = 3'd4; a = 32'h12345678; start = 1'b1;
    step();
    start = 1'b0;
    exp_hi = 32'h12345678;
    chk("mthi_hilo", {hi, lo}, {exp_hi, exp_lo});
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    op = 3'd5; a = 32'hCAFEF00D; start = 1'b1;
    step();
    start = 1'b0;
    exp_lo = 32'hCAFEF00D;
    chk("mtlo_hilo", {hi, lo}, {exp_hi, exp_lo});
    chk("mtlo_busy", 64'(busy), 64'd0);

    // cancel and start together in idle: nothing launches
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("idlecancel_busy", 64'(busy), 64'd0);
    repeat (4) step();
    chk("idlecancel_hilo", {hi, lo}, {exp_hi, exp_lo});
    chk("idlecancel_done", 64'(done), 64'd0);

    // reset in the middle of a divide
    op = 3'd2; a = 32'd99; b = 32'd4; start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("midrst_nodone", 64'(seen), 64'd0);

    // back-to-back: DIV launched in the cycle right after MULT's done
    run_op("b2b_mult", 3'd0, 32'h7FFFFFFF, 32'h80000000, -1, -1);
    run_op("b2b_div",  3'd2, 32'h80000001, 32'd9, -1, -1);

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", ro, ra, rb, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
